// File: rtl/alarm_annunciator_if.sv
// rtl/alarm_annunciator_if.sv - control/status bundle between the security FSM and the buzzer annunciator
interface alarm_annunciator_if;
   logic       i_Start;
   logic [3:0] i_Beep_Count;
   logic       i_Continuous;
   logic       i_Stop;
   logic       o_Buzzer;
   logic       o_Busy;
   logic       o_Done;

   modport master (
      output i_Start, i_Beep_Count, i_Continuous, i_Stop,
      input  o_Buzzer, o_Busy, o_Done
   );

   modport slave (
      input  i_Start, i_Beep_Count, i_Continuous, i_Stop,
      output o_Buzzer, o_Busy, o_Done
   );
endinterface

// File: rtl/alarm_annunciator.sv
// rtl/alarm_annunciator.sv - timed beep-burst / continuous buzzer pattern generator
// Define ANNUNCIATOR_TONE_EN to drive a square-wave tone for a passive piezo during ON.
module alarm_annunciator #(
   parameter int c_BEEP_ON_CNT   = 2500000,
   parameter int c_BEEP_OFF_CNT  = 2500000,
   parameter int c_TONE_HALF_CNT = 6250
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   alarm_annunciator_if.slave   bus
);

   localparam logic [23:0] c_ON_LAST  = 24'(c_BEEP_ON_CNT - 1);
   localparam logic [23:0] c_OFF_LAST = 24'(c_BEEP_OFF_CNT - 1);

   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

   state_t      state, state_nxt;
   logic [23:0] phase_cnt, phase_nxt;
   logic [3:0]  remain, remain_nxt;
   logic        cont, cont_nxt;
   logic        on_entry;
   logic        buzzer_nxt, busy_nxt, done_nxt;

   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase_cnt;
      remain_nxt = remain;
      cont_nxt   = cont;
      on_entry   = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_Start) begin
               if (bus.i_Continuous || bus.i_Beep_Count != 4'd0) begin
                  state_nxt  = ON;
                  cont_nxt   = bus.i_Continuous;
                  remain_nxt = bus.i_Beep_Count;
                  phase_nxt  = 24'd0;
                  on_entry   = 1'b1;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         ON: begin
            // Stop wins over a phase boundary landing in the same cycle.
            if (bus.i_Stop) begin
               state_nxt = IDLE;
               phase_nxt = 24'd0;
               done_nxt  = 1'b1;
            end else if (phase_cnt == c_ON_LAST) begin
               state_nxt = OFF;
               phase_nxt = 24'd0;
               if (!cont)
                  remain_nxt = remain - 4'd1;
            end else begin
               phase_nxt = phase_cnt + 24'd1;
            end
         end
         OFF: begin
            if (bus.i_Stop) begin
               state_nxt = IDLE;
               phase_nxt = 24'd0;
               done_nxt  = 1'b1;
            end else if (phase_cnt == c_OFF_LAST) begin
               phase_nxt = 24'd0;
               if (cont || remain != 4'd0) begin
                  state_nxt = ON;
                  on_entry  = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end else begin
               phase_nxt = phase_cnt + 24'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy_nxt = (state_nxt != IDLE);

`ifdef ANNUNCIATOR_TONE_EN
   localparam logic [15:0] c_TONE_LAST = 16'(c_TONE_HALF_CNT - 1);

   logic [15:0] tone_cnt, tone_cnt_nxt;
   logic        tone_lvl, tone_lvl_nxt;

   // Tone phase restarts high on every ON entry so each beep sounds identical.
   always_comb begin
      tone_cnt_nxt = tone_cnt;
      tone_lvl_nxt = tone_lvl;
      if (on_entry) begin
         tone_cnt_nxt = 16'd0;
         tone_lvl_nxt = 1'b1;
      end else if (state == ON && state_nxt == ON) begin
         if (tone_cnt == c_TONE_LAST) begin
            tone_cnt_nxt = 16'd0;
            tone_lvl_nxt = ~tone_lvl;
         end else begin
            tone_cnt_nxt = tone_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         tone_cnt <= 16'd0;
         tone_lvl <= 1'b0;
      end else begin
         tone_cnt <= tone_cnt_nxt;
         tone_lvl <= tone_lvl_nxt;
      end
   end

   assign buzzer_nxt = (state_nxt == ON) && tone_lvl_nxt;
`else
   logic tone_unused;
   assign tone_unused = ^{on_entry, 16'(c_TONE_HALF_CNT)};
   assign buzzer_nxt  = (state_nxt == ON);
`endif

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state        <= IDLE;
         phase_cnt    <= 24'd0;
         remain       <= 4'd0;
         cont         <= 1'b0;
         bus.o_Buzzer <= 1'b0;
         bus.o_Busy   <= 1'b0;
         bus.o_Done   <= 1'b0;
      end else begin
         state        <= state_nxt;
         phase_cnt    <= phase_nxt;
         remain       <= remain_nxt;
         cont         <= cont_nxt;
         bus.o_Buzzer <= buzzer_nxt;
         bus.o_Busy   <= busy_nxt;
         bus.o_Done   <= done_nxt;
      end
   end

endmodule
